// File: rtl/fill_notification_coalescer_pkg.sv
// Shared types for the fill-notification path feeding the cache-table monitor.
package rme_pkg;

    localparam int unsigned RME_LINE_IDX_W   = 26;
    localparam int unsigned RME_LINE_BYTES   = 64;
    localparam int unsigned LINE_OFFSET_BITS = $clog2(RME_LINE_BYTES);

    typedef struct packed {
        logic [RME_LINE_IDX_W-1:0] line;
        logic [7:0]                size;
    } fill_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } issue_state_t;

endpackage

// File: rtl/fill_notification_coalescer_notif_fifo.sv
// Small synchronous FIFO of pending fill notifications; extra pointer bit separates full from empty.
module notif_fifo
    import rme_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  fill_entry_t wdata,
    output fill_entry_t rdata,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    fill_entry_t mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push && !full)
                wptr_q <= wptr_q + (AW+1)'(1);
            if (pop && !empty)
                rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem_q[wptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem_q[rptr_q[AW-1:0]];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/fill_notification_coalescer.sv
// Accumulates fetch-unit write beats per cache line and issues one paced inc
// notification per line segment to the cache-table monitor.
module fill_notification_coalescer
    import rme_pkg::*;
#(
    parameter int unsigned C_BRAM_ADDR_WIDTH    = 26,
    parameter int unsigned CACHE_LINE_SIZE_BYTE = 64,
    parameter int unsigned BEAT_BYTES           = 16,
    parameter int unsigned FIFO_DEPTH           = 4,
    parameter int unsigned FLUSH_TIMEOUT        = 32
) (
    input  logic                                                   clock,
    input  logic                                                   reset,
    input  logic                                                   wr_valid,
    output logic                                                   wr_ready,
    input  logic [C_BRAM_ADDR_WIDTH+$clog2(CACHE_LINE_SIZE_BYTE)-1:0] wr_byte_addr,
    input  logic [$clog2(BEAT_BYTES):0]                            wr_bytes,
    input  logic                                                   flush,
    output logic                                                   inc,
    output logic [C_BRAM_ADDR_WIDTH-1:0]                           inc_addr,
    output logic [7:0]                                             inc_size,
    input  logic                                                   data_inserted,
    output logic                                                   busy,
    output logic                                                   straddle_err
);

    localparam int unsigned LOB    = $clog2(CACHE_LINE_SIZE_BYTE);
    localparam int unsigned IDLE_W = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
    localparam logic [7:0]  LINE_SZ = 8'(CACHE_LINE_SIZE_BYTE);

    if (C_BRAM_ADDR_WIDTH != RME_LINE_IDX_W) begin : g_bad_addr_w
        $error("C_BRAM_ADDR_WIDTH must match the shared fill_entry_t line width");
    end
    if (CACHE_LINE_SIZE_BYTE > 128 || BEAT_BYTES >= CACHE_LINE_SIZE_BYTE) begin : g_bad_sizes
        $error("line size must be <= 128 and strictly larger than BEAT_BYTES");
    end
    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("FIFO_DEPTH must be at least 2");
    end

    logic                         acc_valid_q, acc_valid_d;
    logic [C_BRAM_ADDR_WIDTH-1:0] acc_line_q,  acc_line_d;
    logic [7:0]                   acc_bytes_q, acc_bytes_d;
    logic                         flush_pend_q, flush_pend_d;
    logic [IDLE_W-1:0]            idle_q, idle_d;
    logic                         straddle_q, straddle_d;
    issue_state_t                 state_q, state_d;
    logic [C_BRAM_ADDR_WIDTH-1:0] inc_addr_q, inc_addr_d;
    logic [7:0]                   inc_size_q, inc_size_d;

    logic                         fifo_push, fifo_pop, fifo_full, fifo_empty;
    fill_entry_t                  push_entry, head_entry;

    logic                         accepted, timeout, flush_req;
    logic [C_BRAM_ADDR_WIDTH-1:0] beat_line;
    logic [7:0]                   beat_bytes, sum, beat_end;

    assign wr_ready   = ~fifo_full & ~reset;
    assign accepted   = wr_valid & wr_ready;
    assign beat_line  = wr_byte_addr[C_BRAM_ADDR_WIDTH+LOB-1:LOB];
    assign beat_bytes = 8'(wr_bytes);
    assign sum        = acc_bytes_q + beat_bytes;
    assign beat_end   = 8'(wr_byte_addr[LOB-1:0]) + beat_bytes;
    assign timeout    = (FLUSH_TIMEOUT != 0) && (idle_q == IDLE_W'(FLUSH_TIMEOUT));
    assign flush_req  = flush | flush_pend_q | timeout;

    always_comb begin
        acc_valid_d     = acc_valid_q;
        acc_line_d      = acc_line_q;
        acc_bytes_d     = acc_bytes_q;
        flush_pend_d    = flush_pend_q;
        straddle_d      = straddle_q;
        fifo_push       = 1'b0;
        push_entry.line = acc_line_q;
        push_entry.size = acc_bytes_q;

        if (accepted) begin
            // A beat takes priority; any flush is held and served on a later cycle.
            flush_pend_d = flush_pend_q | flush;
            if (beat_end > LINE_SZ)
                straddle_d = 1'b1;
            if (!acc_valid_q || beat_line != acc_line_q) begin
                fifo_push   = acc_valid_q;
                acc_valid_d = 1'b1;
                acc_line_d  = beat_line;
                acc_bytes_d = beat_bytes;
            end else begin
                acc_bytes_d = sum;
                if (sum > LINE_SZ)
                    straddle_d = 1'b1;
                if (sum >= LINE_SZ) begin
                    fifo_push       = 1'b1;
                    push_entry.size = (sum > LINE_SZ) ? LINE_SZ : sum;
                    acc_valid_d     = 1'b0;
                    acc_bytes_d     = '0;
                end
            end
        end else if (flush_req) begin
            if (!acc_valid_q) begin
                flush_pend_d = 1'b0;
            end else if (!fifo_full) begin
                fifo_push    = 1'b1;
                acc_valid_d  = 1'b0;
                acc_bytes_d  = '0;
                flush_pend_d = 1'b0;
            end else begin
                flush_pend_d = 1'b1;
            end
        end

        if (accepted || !acc_valid_d)
            idle_d = '0;
        else if (idle_q != IDLE_W'(FLUSH_TIMEOUT))
            idle_d = idle_q + IDLE_W'(1);
        else
            idle_d = idle_q;
    end

    always_comb begin
        state_d    = state_q;
        fifo_pop   = 1'b0;
        inc_addr_d = inc_addr_q;
        inc_size_d = inc_size_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d    = ISSUE;
                    inc_addr_d = head_entry.line;
                    inc_size_d = head_entry.size;
                end
            end
            ISSUE: begin
                fifo_pop = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (data_inserted)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_valid_q  <= 1'b0;
            acc_line_q   <= '0;
            acc_bytes_q  <= '0;
            flush_pend_q <= 1'b0;
            idle_q       <= '0;
            straddle_q   <= 1'b0;
            state_q      <= IDLE;
            inc_addr_q   <= '0;
            inc_size_q   <= '0;
        end else begin
            acc_valid_q  <= acc_valid_d;
            acc_line_q   <= acc_line_d;
            acc_bytes_q  <= acc_bytes_d;
            flush_pend_q <= flush_pend_d;
            idle_q       <= idle_d;
            straddle_q   <= straddle_d;
            state_q      <= state_d;
            inc_addr_q   <= inc_addr_d;
            inc_size_q   <= inc_size_d;
        end
    end

    notif_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clock),
        .rst   (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign inc          = (state_q == ISSUE);
    assign inc_addr     = inc_addr_q;
    assign inc_size     = inc_size_q;
    assign busy         = acc_valid_q | ~fifo_empty | (state_q != IDLE);
    assign straddle_err = straddle_q;

endmodule
